// File: rtl/pack_pkg.sv
// Shared defaults and types for the ping-pong packet sample buffer.
package pack_pkg;

    localparam int NCH_D = 3;
    localparam int DW_D  = 24;
    localparam int QW_D  = 32;
    localparam int TSW_D = 32;
    localparam int AW_D  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        CAP  = 1'b1
    } frm_st_e;

    typedef logic bank_t;

endpackage

// File: rtl/pack_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port returning old data on collision.
module pack_ram_sdp #(
    parameter int W  = 32,
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else       r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pack_buf_pp.sv
// Ping-pong sample frame buffer with timestamp capture, sync-driven bank switch and reader handshake.
module pack_buf_pp
    import pack_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int DW  = DW_D,
    parameter int QW  = QW_D,
    parameter int TSW = TSW_D,
    parameter int AW  = AW_D
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [DW-1:0]     dp_data,
    input  logic              dp_vld,
    input  logic [TSW-1:0]    dp_utc,
    input  logic [TSW-1:0]    dp_ns,
    input  logic              syn_vld,
    input  logic [AW-1:0]     buf_raddr,
    output logic [NCH*QW-1:0] q_ch,
    output logic [TSW-1:0]    q_utc,
    output logic [TSW-1:0]    q_ns,
    output logic [AW-1:0]     buf_waddr,
    output logic              bank_done,
    output logic              done_bank,
    output logic [AW-1:0]     done_cnt,
    input  logic              rd_release,
    input  logic              rel_bank,
    output logic              ovr,
    output logic              full,
    output logic              frame_err,
    input  logic              clr_err
);

    localparam int SLOTS = 2**(AW-1);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

    frm_st_e       r_st, w_st_nxt;
    logic [CW-1:0] r_ch, w_ch_nxt;
    logic          r_vld_q;
    logic          r_drop;
    logic [AW-1:0] r_slot;
    bank_t         r_wr_bank;
    logic          r_sync_pend;
    logic [1:0]    r_own;
    logic          r_bank_done;
    bank_t         r_done_bank;
    logic [AW-1:0] r_done_cnt;
    logic          r_ovr, r_full, r_ferr;

    logic          w_start, w_idle, w_acc, w_full_hit, w_drop_cur, w_last, w_close;
    logic          w_wr_en, w_ts_we, w_ovr_set;
    logic [CW-1:0] w_lane;
    logic [AW-1:0] w_slot_nxt, w_waddr;
    logic [1:0]    w_own_nxt;
    logic [QW-1:0] w_wdata;

    assign w_start    = dp_vld & ~r_vld_q;
    assign w_idle     = (r_st == IDLE);
    assign w_acc      = w_start & w_idle;
    assign w_full_hit = w_acc & (r_slot == AW'(SLOTS));
    // Drop decision is taken at frame start and held for the remaining channels.
    assign w_drop_cur = w_idle ? w_full_hit : r_drop;
    assign w_last     = ((NCH == 1) & w_acc) | (~w_idle & (r_ch == CW'(NCH-1)));
    assign w_close    = (syn_vld & w_idle & ~w_start) | (w_last & (r_sync_pend | syn_vld));
    assign w_slot_nxt = r_slot + AW'(w_last & ~w_drop_cur);

    assign w_lane     = w_idle ? '0 : r_ch;
    assign w_wr_en    = ~rst & (w_acc | ~w_idle) & ~w_drop_cur;
    assign w_ts_we    = ~rst & w_acc & ~w_full_hit;
    assign w_waddr    = {r_wr_bank, r_slot[AW-2:0]};
    assign w_wdata    = QW'(dp_data);
    assign w_ovr_set  = w_close & r_own[~r_wr_bank];

    always_comb begin
        w_own_nxt = r_own;
        if (rd_release) w_own_nxt[rel_bank] = 1'b0;
        if (w_close)    w_own_nxt[r_wr_bank] = 1'b1;
    end

    always_comb begin
        w_st_nxt = r_st;
        w_ch_nxt = r_ch;
        case (r_st)
            IDLE: begin
                if (w_start && (NCH > 1)) begin
                    w_st_nxt = CAP;
                    w_ch_nxt = CW'(1);
                end
            end
            CAP: begin
                if (r_ch == CW'(NCH-1)) begin
                    w_st_nxt = IDLE;
                    w_ch_nxt = '0;
                end else begin
                    w_ch_nxt = r_ch + CW'(1);
                end
            end
            default: w_st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_st <= IDLE;
            r_ch <= '0;
        end else begin
            r_st <= w_st_nxt;
            r_ch <= w_ch_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_vld_q     <= 1'b0;
            r_drop      <= 1'b0;
            r_slot      <= '0;
            r_wr_bank   <= 1'b0;
            r_sync_pend <= 1'b0;
            r_own       <= '0;
            r_bank_done <= 1'b0;
            r_done_bank <= 1'b0;
            r_done_cnt  <= '0;
            r_ovr       <= 1'b0;
            r_full      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_vld_q     <= dp_vld;
            if (w_acc) r_drop <= w_full_hit;
            r_bank_done <= w_close;
            if (w_close) begin
                r_done_bank <= r_wr_bank;
                r_done_cnt  <= w_slot_nxt;
                r_wr_bank   <= ~r_wr_bank;
                r_slot      <= '0;
            end else begin
                r_slot      <= w_slot_nxt;
            end
            // A sync that cannot close now is remembered until the frame's last channel.
            r_sync_pend <= w_close ? 1'b0 : (r_sync_pend | (syn_vld & (~w_idle | w_start)));
            r_own       <= w_own_nxt;
            r_ovr       <= w_ovr_set | (r_ovr & ~clr_err);
            r_full      <= w_full_hit | (r_full & ~clr_err);
            r_ferr      <= (w_start & ~w_idle) | (r_ferr & ~clr_err);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic w_we;
        assign w_we = w_wr_en & (w_lane == CW'(k));
        pack_ram_sdp #(.W(QW), .AW(AW)) u_ram (
            .i_clk   (clk_sys),
            .i_rst   (rst),
            .i_we    (w_we),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (buf_raddr),
            .o_rdata (q_ch[k*QW +: QW])
        );
    end

    pack_ram_sdp #(.W(TSW), .AW(AW)) u_ram_utc (
        .i_clk   (clk_sys),
        .i_rst   (rst),
        .i_we    (w_ts_we),
        .i_waddr (w_waddr),
        .i_wdata (dp_utc),
        .i_raddr (buf_raddr),
        .o_rdata (q_utc)
    );

    pack_ram_sdp #(.W(TSW), .AW(AW)) u_ram_ns (
        .i_clk   (clk_sys),
        .i_rst   (rst),
        .i_we    (w_ts_we),
        .i_waddr (w_waddr),
        .i_wdata (dp_ns),
        .i_raddr (buf_raddr),
        .o_rdata (q_ns)
    );

    assign buf_waddr = w_waddr;
    assign bank_done = r_bank_done;
    assign done_bank = r_done_bank;
    assign done_cnt  = r_done_cnt;
    assign ovr       = r_ovr;
    assign full      = r_full;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_pack_buf_pp.sv
// Scoreboard bench for pack_buf_pp: frame-level reference model, queued close/read expectations.
module tb_pack_buf_pp;

    localparam int NCH = 3, DW = 24, QW = 32, TSW = 32, AW = 12;
    localparam int SLOTS = 2**(AW-1), NA = 2**AW;

    logic              clk_sys = 1'b0, rst = 1'b1;
    logic [DW-1:0]     dp_data = '0;
    logic              dp_vld = 1'b0, syn_vld = 1'b0, rd_release = 1'b0, rel_bank = 1'b0, clr_err = 1'b0;
    logic [TSW-1:0]    dp_utc = '0, dp_ns = '0;
    logic [AW-1:0]     buf_raddr = '0;
    logic [NCH*QW-1:0] q_ch;
    logic [TSW-1:0]    q_utc, q_ns;
    logic [AW-1:0]     buf_waddr, done_cnt;
    logic              bank_done, done_bank, ovr, full, frame_err;

    pack_buf_pp #(.NCH(NCH), .DW(DW), .QW(QW), .TSW(TSW), .AW(AW)) dut (
        .clk_sys(clk_sys), .rst(rst), .dp_data(dp_data), .dp_vld(dp_vld), .dp_utc(dp_utc),
        .dp_ns(dp_ns), .syn_vld(syn_vld), .buf_raddr(buf_raddr), .q_ch(q_ch), .q_utc(q_utc),
        .q_ns(q_ns), .buf_waddr(buf_waddr), .bank_done(bank_done), .done_bank(done_bank),
        .done_cnt(done_cnt), .rd_release(rd_release), .rel_bank(rel_bank), .ovr(ovr),
        .full(full), .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_err = 0;

    typedef struct { bit bank; int cnt; bit ovr; } close_t;
    typedef struct { logic [NCH*QW-1:0] ch; logic [TSW-1:0] utc, ns; int addr; } rd_t;
    close_t cq[$];
    rd_t    rq[$];

    // Reference model: what each address holds, and the buffer's architectural state.
    logic [QW-1:0]  m_ch  [NA][NCH];
    logic [TSW-1:0] m_utc [NA];
    logic [TSW-1:0] m_ns  [NA];
    int             wlist[$];
    bit             m_bank;
    int             m_slot;
    bit [1:0]       m_own;
    bit             m_ovr, m_full, m_ferr;
    logic           rd_req = 1'b0, rd_d = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int m_addr();
        return (int'(m_bank) << (AW-1)) | (m_slot % SLOTS);
    endfunction

    function automatic void m_close();
        close_t e;
        m_ovr = m_ovr | m_own[!m_bank];
        m_own[m_bank] = 1'b1;
        e.bank = m_bank; e.cnt = m_slot; e.ovr = m_ovr;
        cq.push_back(e);
        m_bank = !m_bank;
        m_slot = 0;
    endfunction

    function automatic void m_reset();
        m_bank = 0; m_slot = 0; m_own = '0; m_ovr = 0; m_full = 0; m_ferr = 0;
    endfunction

    always @(posedge clk_sys) rd_d <= rd_req;

    always @(negedge clk_sys) begin
        close_t e;
        rd_t    r;
        if (bank_done) begin
            if (cq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_bank_done: got bank=%0d cnt=%0d expected none", done_bank, done_cnt);
            end else begin
                e = cq.pop_front();
                chk("done_bank", done_bank, e.bank);
                chk("done_cnt", done_cnt, e.cnt);
                chk("ovr_at_close", ovr, e.ovr);
            end
        end
        if (rd_d) begin
            if (rq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL read_queue: got read with no expectation expected entry");
            end else begin
                r = rq.pop_front();
                chk($sformatf("q_ch@%0h", r.addr), q_ch, r.ch);
                chk($sformatf("q_utc@%0h", r.addr), q_utc, r.utc);
                chk($sformatf("q_ns@%0h", r.addr), q_ns, r.ns);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ovr"}, ovr, m_ovr);
        chk({tag, ".full"}, full, m_full);
        chk({tag, ".frame_err"}, frame_err, m_ferr);
        chk({tag, ".waddr"}, buf_waddr, m_addr());
    endtask

    task automatic frame(input logic [DW-1:0] base, input logic [TSW-1:0] utc, input logic [TSW-1:0] ns,
                         input int sync_at, input int err_at, input int clr_at);
        bit drop;
        int a;
        logic [DW-1:0] dk;
        drop = (m_slot == SLOTS);
        a = m_addr();
        for (int k = 0; k < NCH; k++) begin
            dk = base + DW'(k);
            dp_data = dk; dp_utc = utc; dp_ns = ns;
            dp_vld  = (k == 0) || (k == err_at);
            syn_vld = (k == sync_at);
            clr_err = (k == clr_at);
            if (k == clr_at) begin m_ovr = 0; m_full = 0; m_ferr = 0; end
            if (k == 0 && drop) m_full = 1;
            if (!drop) begin
                m_ch[a][k] = QW'(dk);
                if (k == 0) begin m_utc[a] = utc; m_ns[a] = ns; wlist.push_back(a); end
            end
            if (k == err_at) m_ferr = 1;
            if (k == NCH-1) begin
                if (!drop) m_slot++;
                if (sync_at >= 0) m_close();
            end
            @(negedge clk_sys);
        end
        dp_vld = 0; syn_vld = 0; clr_err = 0;
        @(negedge clk_sys);
    endtask

    task automatic sync_idle();
        syn_vld = 1; m_close();
        @(negedge clk_sys);
        syn_vld = 0;
        @(negedge clk_sys);
    endtask

    task automatic release_bank(input bit b);
        rd_release = 1; rel_bank = b; m_own[b] = 0;
        @(negedge clk_sys);
        rd_release = 0;
    endtask

    task automatic clear_flags();
        clr_err = 1; m_ovr = 0; m_full = 0; m_ferr = 0;
        @(negedge clk_sys);
        clr_err = 0;
    endtask

    task automatic rd(input int a);
        rd_t r;
        for (int k = 0; k < NCH; k++) r.ch[k*QW +: QW] = m_ch[a][k];
        r.utc = m_utc[a]; r.ns = m_ns[a]; r.addr = a;
        rq.push_back(r);
        buf_raddr = AW'(a); rd_req = 1;
        @(negedge clk_sys);
        rd_req = 0;
        @(negedge clk_sys);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".bank_done"}, bank_done, 0);
        chk({tag, ".done_bank"}, done_bank, 0);
        chk({tag, ".done_cnt"}, done_cnt, 0);
        chk({tag, ".flags"}, {ovr, full, frame_err}, 0);
        chk({tag, ".waddr"}, buf_waddr, 0);
        chk({tag, ".q"}, {q_ch, q_utc, q_ns}, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        @(negedge clk_sys);
        check_reset_outputs(tag);
        rst = 0;
        m_reset();
    endtask

    initial begin
        int a, x;
        logic [DW-1:0] xd;
        m_reset();
        idle(2);
        do_reset("reset0");

        // Three frames, close from idle, read back middle slot.
        frame(24'hA00000, 32'd5, 32'd100, -1, -1, -1);
        frame(24'hB00000, 32'd5, 32'd200, -1, -1, -1);
        frame(24'hC00000, 32'd5, 32'd300, -1, -1, -1);
        sync_idle();
        rd(1);
        chk("b1.q_ns_literal", q_ns, 200);
        check_state("basic");

        // Sync during a frame: frame lands in old bank, switch follows its last channel.
        do_reset("reset1");
        frame(24'h111111, 32'd6, 32'd10, -1, -1, -1);
        frame(24'h222222, 32'd6, 32'd20, 1, -1, -1);
        idle(1);
        chk("midsync.waddr_literal", buf_waddr, 12'h800);
        check_state("midsync");
        rd(1);

        // Overrun into a bank still owned, then release and clear.
        sync_idle();
        idle(1);
        check_state("ovr_set");
        chk("ovr_literal", ovr, 1);
        release_bank(0);
        release_bank(1);
        clear_flags();
        idle(1);
        check_state("ovr_clr");
        sync_idle();
        idle(1);
        check_state("ovr_clean");

        // Frame start during capture, with clr_err in the same cycle (set wins).
        a = m_slot;
        frame(24'h333333, 32'd7, 32'd30, -1, 2, 2);
        chk("ferr.slot_step", m_slot, a + 1);
        check_state("ferr");
        clear_flags();
        idle(1);
        check_state("ferr_clr");

        // Reset mid-frame with a pending sync; no close may follow.
        release_bank(0); release_bank(1);
        a = m_addr();
        xd = 24'h5A5A5A;
        dp_vld = 1; dp_data = xd; syn_vld = 1; dp_utc = 32'd9; dp_ns = 32'd99;
        if (m_slot < SLOTS) begin m_ch[a][0] = QW'(xd); m_utc[a] = 32'd9; m_ns[a] = 32'd99; end
        @(negedge clk_sys);
        dp_vld = 0; syn_vld = 0;
        do_reset("reset_mid");
        frame(24'h444444, 32'd8, 32'd40, -1, -1, -1);
        idle(3);
        check_state("after_rst");
        rd(0);

        // Randomized mix of operations.
        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(0, 9);
            if (x < 5)
                frame(DW'($urandom), $urandom, $urandom,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NCH-1)) : -1,
                      ($urandom_range(0, 4) == 0) ? 2 : -1,
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NCH-1)) : -1);
            else if (x == 5) sync_idle();
            else if (x == 6) release_bank(1'($urandom_range(0, 1)));
            else if (x == 7) clear_flags();
            else if (wlist.size() > 0) rd(wlist[$urandom_range(0, wlist.size()-1)]);
            idle(1);
            check_state($sformatf("rnd%0d", i));
        end

        // Fill one bank past capacity.
        sync_idle();
        a = m_addr();
        for (int i = 0; i <= SLOTS; i++) frame(DW'(i * 7), i, i + 1, -1, -1, -1);
        idle(1);
        check_state("full");
        chk("full_literal", full, 1);
        rd(a);
        sync_idle();
        idle(3);

        chk("close_queue_drained", cq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
